// File: rtl/instr_queue_pkg.sv
// Shared constants and width helpers for the instruction queue.
package instr_queue_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 4;
  localparam int PTR_W_DEF  = $clog2(DEPTH_DEF);
  localparam int CNT_W_DEF  = PTR_W_DEF + 1;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // One extra bit so a completely full queue (count == DEPTH) is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/instr_queue_mem.sv
// DEPTH x DATA_W register file: one synchronous write port, one asynchronous read port.
module instr_queue_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the storage is reset deliberately so out_data reads zero after reset;
  // this rules out RAM inference, which is fine at this size.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_queue.sv
// Instruction fetch queue: valid/ready FIFO with flush. Optional empty-queue
// bypass is enabled by defining INSTR_QUEUE_BYPASS_EN.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [cnt_width(DEPTH)-1:0]  count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W-1:0] rd_data;
  logic              push, pop, bypass, store, take;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    push      = in_valid && in_ready;
    bypass    = 1'b0;
    out_valid = !empty;
    out_data  = rd_data;
`ifdef INSTR_QUEUE_BYPASS_EN
    bypass = empty && in_valid && !flush;
    if (bypass) begin
      out_valid = 1'b1;
      out_data  = in_data;
    end
`endif
    pop   = out_valid && out_ready;
    // A bypassed word taken in the same cycle never touches storage.
    store = push && !(bypass && out_ready);
    take  = pop && !empty;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PTR_W'(1);
      if (take)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (store && !take)      count <= count + CNT_W'(1);
      else if (take && !store) count <= count - CNT_W'(1);
    end
  end

  instr_queue_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (store && !flush),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 32: instruction word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: number of entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port flush, input, 1 bit: discard all queued words.
REQ-006 SHALL have port in_valid, input, 1 bit: producer offers in_data.
REQ-007 SHALL have port in_ready, output, 1 bit: queue accepts a word this cycle.
REQ-008 SHALL have port in_data, input, DATA_W bits: fetched instruction word.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data holds a valid instruction.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer takes out_data this cycle.
REQ-011 SHALL have port out_data, output, DATA_W bits: oldest queued instruction.
REQ-012 SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-013 SHALL have ports full and empty, output, 1 bit each: count==DEPTH and count==0.

Function
REQ-014 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-015 in_ready SHALL equal !full; no push when full, even if a pop happens the same cycle.
REQ-016 out_valid SHALL equal !empty; out_data SHALL be the entry at the read pointer, driven from registered storage.
REQ-017 Push-to-out_valid latency SHALL be 1 cycle when empty.
REQ-018 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-019 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or go below 0.
REQ-020 Order SHALL be strictly FIFO; no word is duplicated or lost except by flush or reset.
REQ-021 flush SHALL take priority over push and pop: next cycle count=0 and both pointers=0; any push or pop in the flush cycle is discarded.
REQ-022 Storage contents SHALL NOT be cleared by flush; out_data after flush is unspecified but stable.

Reset
REQ-023 Reset SHALL give count=0, pointers=0, empty=1, full=0, out_valid=0, in_ready=1, and all storage entries=0, so out_data=0.
REQ-024 Reset SHALL override flush, push and pop in the same cycle.
REQ-025 Reset asserted mid-operation SHALL discard all queued words within one cycle.

Configuration
REQ-026 Macro INSTR_QUEUE_BYPASS_EN SHALL enable the empty-queue bypass behaviour in REQ-027 and REQ-028.
REQ-027 With bypass, when empty && in_valid && !flush: out_valid=1 and out_data=in_data combinationally.
REQ-028 With bypass, if out_ready is also high that cycle, the word is consumed without being stored and count stays 0; otherwise the word is stored normally.
REQ-029 Without the macro, behaviour SHALL be exactly REQ-014 to REQ-025, with latency 1.

Structure
REQ-030 Package instr_queue_pkg SHALL hold the DATA_W and DEPTH defaults and the pointer-width and count-width constants.
REQ-031 Storage SHALL be a sub-module instr_queue_mem: DEPTH x DATA_W registers, single write port, asynchronous read port, synchronous reset to zero.
REQ-032 Pointer, count and handshake control SHALL reside in instr_queue.

Verification
REQ-033 Reset, then push 0x8C010004, 0x00221820, 0xAC030008 with out_ready=0 -> count=3, out_data=0x8C010004, in_ready=1.
REQ-034 Fill to DEPTH=4, hold in_valid=1 with out_ready=0 -> full=1, in_ready=0, count stays 4, and the fifth word is not stored.
REQ-035 Full queue with in_valid=1 and out_ready=1 -> one pop per cycle, count=3, then refill to 4; output order preserved across pointer wrap (≥10 words streamed).
REQ-036 count=2 and flush=1 together with push -> next cycle count=0, empty=1, pushed word absent.
REQ-037 rst=1 while count=3 -> next cycle count=0, out_data=0, in_ready=1.
REQ-038 With INSTR_QUEUE_BYPASS_EN, empty queue, in_valid=1, in_data=0x08000010, out_ready=1 -> out_valid=1 and out_data=0x08000010 in the same cycle, count stays 0; without the macro, out_valid rises one cycle later.
